// File: rtl/led_sequencer.sv
// LED pattern sequencer: binary, gray, bouncing scan and breathe (PWM) patterns.
// The breathe generator is built only when LED_SEQUENCER_BREATHE_EN is defined.
module led_sequencer #(
   parameter int LEDS      = 4,
   parameter int LOG2DELAY = 23,
   parameter int PWM_BITS  = 8
) (
   input  logic            clki,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      mode,
   output logic [LEDS-1:0] led,
   output logic            tick
);

   localparam int               POS_W    = (LEDS > 1) ? $clog2(LEDS) : 1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(LEDS - 1);

   logic [LOG2DELAY-1:0] prescaler_q, prescaler_d;
   logic [LEDS-1:0]      step_q, step_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic                 dir_up_q, dir_up_d;
   logic [LEDS-1:0]      led_q, led_d;
   logic                 tick_q, tick_d;
   logic                 step_stb;

   // Prescaler, step counter and bouncing scan position.
   always_comb begin
      step_stb    = en && (&prescaler_q);
      prescaler_d = prescaler_q;
      step_d      = step_q;
      pos_d       = pos_q;
      dir_up_d    = dir_up_q;
      if (en) begin
         prescaler_d = prescaler_q + LOG2DELAY'(1);
      end
      if (step_stb) begin
         step_d = step_q + LEDS'(1);
         if (LEDS > 1) begin
            if (dir_up_q) begin
               if (pos_q == POS_LAST) begin
                  pos_d    = pos_q - POS_W'(1);
                  dir_up_d = 1'b0;
               end else begin
                  pos_d = pos_q + POS_W'(1);
               end
            end else begin
               if (pos_q == '0) begin
                  pos_d    = POS_W'(1);
                  dir_up_d = 1'b1;
               end else begin
                  pos_d = pos_q - POS_W'(1);
               end
            end
         end
      end
   end

`ifdef LED_SEQUENCER_BREATHE_EN
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic                duty_up_q, duty_up_d;
   logic                breathe_on;

   // Duty bounces between 0 and full scale; pwm runs even while en is low.
   always_comb begin
      duty_d    = duty_q;
      duty_up_d = duty_up_q;
      pwm_d     = pwm_q + PWM_BITS'(1);
      if (step_stb) begin
         if (duty_up_q) begin
            if (duty_q == DUTY_MAX) begin
               duty_d    = duty_q - PWM_BITS'(1);
               duty_up_d = 1'b0;
            end else begin
               duty_d = duty_q + PWM_BITS'(1);
            end
         end else begin
            if (duty_q == '0) begin
               duty_d    = PWM_BITS'(1);
               duty_up_d = 1'b1;
            end else begin
               duty_d = duty_q - PWM_BITS'(1);
            end
         end
      end
   end

   assign breathe_on = (pwm_q < duty_q);

   always_ff @(posedge clki) begin
      if (rst) begin
         duty_q    <= '0;
         duty_up_q <= 1'b1;
         pwm_q     <= '0;
      end else begin
         duty_q    <= duty_d;
         duty_up_q <= duty_up_d;
         pwm_q     <= pwm_d;
      end
   end
`endif

   // Output decode always reflects the current registered generator state.
   always_comb begin
      tick_d = step_stb;
      case (mode)
         2'b01:   led_d = step_q ^ (step_q >> 1);
         2'b10:   led_d = LEDS'(1) << pos_q;
`ifdef LED_SEQUENCER_BREATHE_EN
         2'b11:   led_d = {LEDS{breathe_on}};
`endif
         default: led_d = step_q;
      endcase
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         prescaler_q <= '0;
         step_q      <= '0;
         pos_q       <= '0;
         dir_up_q    <= 1'b1;
         led_q       <= '0;
         tick_q      <= 1'b0;
      end else begin
         prescaler_q <= prescaler_d;
         step_q      <= step_d;
         pos_q       <= pos_d;
         dir_up_q    <= dir_up_d;
         led_q       <= led_d;
         tick_q      <= tick_d;
      end
   end

   assign led  = led_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a 4-LED instance and a 1-LED instance share stimulus.
// Breathe checks are compiled in when LED_SEQUENCER_BREATHE_EN is defined.
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [3:0] led_a;
   logic       tick_a;
   logic [0:0] led_b;
   logic       tick_b;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   led_sequencer #(.LEDS(4), .LOG2DELAY(2), .PWM_BITS(2)) dut_a (
      .clki(clk), .rst(rst), .en(en), .mode(mode), .led(led_a), .tick(tick_a)
   );

   led_sequencer #(.LEDS(1), .LOG2DELAY(2), .PWM_BITS(2)) dut_b (
      .clki(clk), .rst(rst), .en(en), .mode(mode), .led(led_b), .tick(tick_b)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves rst low and en high; the next cycle() is the first enabled edge.
   task automatic do_reset(input logic [1:0] m);
      rst  = 1'b1;
      en   = 1'b1;
      mode = m;
      repeat (3) cycle();
      check_eq("rst_led_a", 16'(led_a), 16'h0);
      check_eq("rst_tick_a", 16'(tick_a), 16'h0);
      check_eq("rst_led_b", 16'(led_b), 16'h0);
      rst = 1'b0;
   endtask

   logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
   logic [3:0] scan_tab [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0010};
   logic [1:0] duty_tab [8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] prev;
      int         on_cnt;
      int         wait_n;

      // Binary: tick on every 4th edge, led shows step one edge later.
      do_reset(2'b00);
      for (int k = 1; k <= 68; k++) begin
         cycle();
         check_eq($sformatf("bin_tick k=%0d", k), 16'(tick_a), 16'((k % 4) == 0));
         check_eq($sformatf("bin_led k=%0d", k), 16'(led_a), 16'(((k - 1) / 4) % 16));
      end

      // Gray: table sequence, exactly one bit flips per step.
      do_reset(2'b01);
      prev = 4'd0;
      for (int k = 1; k <= 64; k++) begin
         cycle();
         check_eq($sformatf("gray_led k=%0d", k), 16'(led_a), 16'(gray_tab[(k - 1) / 4]));
         if (k > 1 && ((k - 1) % 4) == 0)
            check_eq($sformatf("gray_onebit k=%0d", k), 16'($countones(led_a ^ prev)), 16'd1);
         prev = led_a;
      end

      // Scan: bouncing one-hot on 4 LEDs; a single LED stays lit.
      do_reset(2'b10);
      for (int k = 1; k <= 32; k++) begin
         cycle();
         check_eq($sformatf("scan_led k=%0d", k), 16'(led_a), 16'(scan_tab[(k - 1) / 4]));
         check_eq($sformatf("scan1_led k=%0d", k), 16'(led_b), 16'd1);
      end

`ifdef LED_SEQUENCER_BREATHE_EN
      // Breathe: led on while pwm (edge count mod 4) is below the duty of that step.
      do_reset(2'b11);
      on_cnt = 0;
      for (int k = 1; k <= 32; k++) begin
         cycle();
         check_eq($sformatf("breathe_led k=%0d", k), 16'(led_a),
                  ((((k - 1) % 4) < int'(duty_tab[(k - 1) / 4])) ? 16'hF : 16'h0));
         if (k >= 9 && k <= 12 && led_a == 4'hF) on_cnt++;
      end
      check_eq("breathe_duty2_on", 16'(on_cnt), 16'd2);
`else
      // Without breathe, mode 11 is plain binary.
      do_reset(2'b11);
      for (int k = 1; k <= 20; k++) begin
         cycle();
         check_eq($sformatf("m11_led k=%0d", k), 16'(led_a), 16'(((k - 1) / 4) % 16));
      end
`endif

      // Freeze with en low mid-count, then resume without losing a step.
      do_reset(2'b00);
      repeat (10) cycle();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_eq($sformatf("frz_led i=%0d", i), 16'(led_a), 16'd2);
         check_eq($sformatf("frz_tick i=%0d", i), 16'(tick_a), 16'd0);
      end
      en = 1'b1;
      for (int j = 11; j <= 13; j++) begin
         cycle();
         check_eq($sformatf("resume_tick j=%0d", j), 16'(tick_a), 16'((j % 4) == 0));
         check_eq($sformatf("resume_led j=%0d", j), 16'(led_a), 16'((j - 1) / 4));
      end
      // Three steps taken: scan position 3, step counter 3.
      mode = 2'b10;
      cycle();
      check_eq("mode_to_scan", 16'(led_a), 16'b1000);
      mode = 2'b00;
      cycle();
      check_eq("mode_back_step", 16'(led_a), 16'd3);

      // Reset lands on the same edge as a step strobe.
      do_reset(2'b00);
      repeat (7) cycle();
      check_eq("pre_rst_led", 16'(led_a), 16'd1);
      rst = 1'b1;
      cycle();
      check_eq("midrst_led", 16'(led_a), 16'd0);
      check_eq("midrst_tick", 16'(tick_a), 16'd0);
      rst = 1'b0;
      // Tick is high during the 5th clock period after rst drops, i.e. after the 4th edge.
      wait_n = 0;
      while (tick_a !== 1'b1 && wait_n < 20) begin
         cycle();
         wait_n++;
      end
      check_eq("first_tick_edges", 16'(wait_n), 16'd4);
      check_eq("post_rst_led", 16'(led_a), 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter LEDS, default 4: number of LED outputs, legal range 1..16.
REQ-002 SHALL have parameter LOG2DELAY, default 23: prescaler width, so there is one step every 2^LOG2DELAY enabled cycles, legal range 1..31.
REQ-003 SHALL have parameter PWM_BITS, default 8: breathe duty/PWM resolution, legal range 2..12.
REQ-004 SHALL have port clki, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: advance enable; when low, all internal state holds.
REQ-007 SHALL have port mode, input, 2 bits: 00 binary, 01 gray, 10 scan, 11 breathe.
REQ-008 SHALL have port led, output, LEDS bits: registered LED drive; bit LEDS-1 maps to led0 of the legacy pinout.
REQ-009 SHALL have port tick, output, 1 bit: registered one-cycle pulse marking each step.

Function
REQ-010 SHALL increment a LOG2DELAY-bit prescaler by 1 on each cycle with en=1, wrapping from all-ones to 0.
REQ-011 SHALL raise an internal step strobe in any cycle where en=1 and the prescaler is all-ones; tick SHALL equal this strobe delayed by one cycle.
REQ-012 SHALL, on each step strobe, increment the LEDS-bit step counter modulo 2^LEDS, with all-ones wrapping to 0.
REQ-013 SHALL, on each step strobe, move the scan position one place in its current direction: dir up means pos+1, dir down means pos-1.
REQ-014 SHALL reverse the scan direction as it moves, so pos=LEDS-1 with dir up goes to LEDS-2 with dir down, and pos=0 with dir down goes to 1 with dir up.
REQ-015 SHALL hold the scan position at 0 when LEDS=1.
REQ-016 SHALL, on each step strobe, move the PWM_BITS-bit duty value one place in its current direction.
REQ-017 SHALL reverse the duty direction at its limits: from 2^PWM_BITS-1 it goes down, from 0 it goes up, with no wrap.
REQ-018 SHALL increment a free-running PWM_BITS-bit pwm counter every cycle, independent of en.
REQ-019 SHALL register led every cycle, one cycle after the state it reflects: mode 00 gives led=step; mode 01 gives led=step^(step>>1); mode 10 gives a one-hot led with bit pos set; mode 11 sets all bits to (pwm<duty).
REQ-020 SHALL keep all four generators running regardless of mode.
REQ-021 SHALL make a mode change visible on led in the next cycle, without resetting any generator.
REQ-022 SHALL let en=0 freeze the prescaler, step, pos, dir, duty and tick=0, while led keeps being recomputed from the frozen state (pwm still runs).

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set prescaler=0, step=0, pos=0, dir=up, duty=0, duty direction=up, pwm=0, led=0 and tick=0.
REQ-024 SHALL give rst priority over en and over step strobes, including a strobe in the same cycle.
REQ-025 SHALL, in the first cycle after rst deasserts, treat en=1 as the first prescaler increment from 0.

Configuration
REQ-026 SHALL include the breathe generator (duty, direction, pwm counter) and mode 11 as specified when macro LED_SEQUENCER_BREATHE_EN is defined.
REQ-027 SHALL, when LED_SEQUENCER_BREATHE_EN is undefined, omit the breathe registers and make mode 11 behave exactly as mode 00.

Verification
REQ-028 SHALL verify binary mode: LEDS=4, LOG2DELAY=2, mode=00, en=1 after reset -> tick every 4th cycle; led steps 0,1,2,...,15,0 with each value held 4 cycles.
REQ-029 SHALL verify gray mode: mode=01, same setup -> led sequence 0,1,3,2,6,7,5,4,12,...; exactly one bit changes per step.
REQ-030 SHALL verify scan mode: LEDS=4, mode=10 -> led 0001,0010,0100,1000,0100,0010,0001,0010 across successive steps; with LEDS=1 led stays 1.
REQ-031 SHALL verify breathe mode: PWM_BITS=2, mode=11 -> duty follows 0,1,2,3,2,1,0,1; at duty=2 led is all-ones for 2 of every 4 cycles.
REQ-032 SHALL verify en and mode change: drop en for 10 cycles mid-count -> led and tick frozen, no step lost; switch mode 00->10 -> led becomes one-hot on the next cycle, step counter unchanged.
REQ-033 SHALL verify mid-run reset: assert rst in the same cycle as a step strobe -> next cycle all outputs 0, and the first tick comes 2^LOG2DELAY+1 cycles after rst deasserts.
